regfile_alu_pipe: RTL

Parametrised successor to the single-cycle register-file/ALU datapath. It adds configurable width and register count, a two-stage issue/writeback pipeline with result forwarding, a flag-load-gated Status register, and an iterative multi-cycle multiply with a busy handshake. It sits between the control unit (opcode decode, immediate generation) and the memory/writeback path of the CPU.

---
 rtl/regfile_alu_pipe.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/regfile_alu_pipe.sv
// regfile_alu_pipe: parametrised register file + ALU with a one-register
// writeback stage, WB-to-read forwarding, a flag-gated Status register and
// an iterative shift-add multiplier that blocks issue while it runs.
//
// Handshake: an operation is taken on any rising edge where in_valid=1 and
// busy=0. Issue fields are don't-care otherwise. wb_valid is a one-cycle
// pulse per completed op with W=1; there is no back-pressure on writeback.
module regfile_alu_pipe #(
  parameter int WIDTH    = 64,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = NREGS - 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             W,
  input  logic [AW-1:0]    SA,
  input  logic [AW-1:0]    SB,
  input  logic [AW-1:0]    DA,
  input  logic [4:0]       FS,
  input  logic             C0,
  input  logic [WIDTH-1:0] K,
  input  logic             K_SEL,
  input  logic             EN_B,
  input  logic             FL,
  output logic             busy,
  output logic             wb_valid,
  output logic [AW-1:0]    wb_addr,
  output logic [WIDTH-1:0] wb_data,
  output logic [3:0]       Status,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data,
  output logic [0:0]       dbg_state
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [AW-1:0]  ZA       = AW'(ZERO_REG);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  logic [WIDTH-1:0] regs_q [NREGS];

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mplier_q, acc_q;
  logic [SHW-1:0]   cnt_q;
  logic [AW-1:0]    mdest_q;
  logic             mw_q, mfl_q;

  logic             wb_valid_q, wb_valid_d;
  logic [AW-1:0]    wb_addr_q, wb_addr_d;
  logic [WIDTH-1:0] wb_data_q, wb_data_d;
  logic [3:0]       status_q, status_d;

  logic             issue, is_mul;
  logic [WIDTH-1:0] src_a, src_b, b_raw, a_op, b_op;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] alu_res, acc_step;
  logic             alu_c, alu_v;
  logic [3:0]       alu_flags;

  assign busy      = (state_q == S_MUL);
  assign issue     = in_valid && !busy;
  assign is_mul    = !EN_B && (FS[4:2] == 3'b110);
  assign wb_valid  = wb_valid_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign Status    = status_q;
  assign dbg_data  = regs_q[dbg_addr];
  assign dbg_state = state_q;

  // Read ports: the zero register reads 0 and is never forwarded; otherwise
  // a pending writeback to the same address overrides the regfile.
  always_comb begin
    if (SA == ZA)
      src_a = '0;
    else if (wb_valid_q && (wb_addr_q == SA))
      src_a = wb_data_q;
    else
      src_a = regs_q[SA];

    if (SB == ZA)
      src_b = '0;
    else if (wb_valid_q && (wb_addr_q == SB))
      src_b = wb_data_q;
    else
      src_b = regs_q[SB];
  end

  // Single-cycle ALU and its flags.
  always_comb begin
    b_raw   = K_SEL ? K : src_b;
    a_op    = src_a ^ {WIDTH{FS[0]}};
    b_op    = b_raw ^ {WIDTH{FS[1]}};
    sum_ext = {1'b0, a_op} + {1'b0, b_op} + {{WIDTH{1'b0}}, C0};
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_res = '0;
    case (FS[4:2])
      3'b000: alu_res = a_op & b_op;
      3'b001: alu_res = a_op | b_op;
      3'b010: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (a_op[WIDTH-1] == b_op[WIDTH-1]) &&
                  (sum_ext[WIDTH-1] != a_op[WIDTH-1]);
      end
      3'b011: alu_res = a_op ^ b_op;
      3'b100: alu_res = a_op << b_op[SHW-1:0];
      3'b101: alu_res = a_op >> b_op[SHW-1:0];
      default: alu_res = '0;  // MUL goes through the FSM; 111 is reserved
    endcase
    if (EN_B) begin
      alu_res = b_op;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
    end
    alu_flags = {alu_v, alu_c, alu_res[WIDTH-1], (alu_res == '0)};
  end

  // One shift-add step of the multiplier.
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Next state of the FSM, the WB register and Status.
  always_comb begin
    state_d    = state_q;
    wb_valid_d = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    status_d   = status_q;
    if (state_q == S_MUL) begin
      if (cnt_q == CNT_LAST) begin
        state_d    = S_IDLE;
        wb_valid_d = mw_q;
        wb_addr_d  = mdest_q;
        wb_data_d  = acc_step;
        if (mfl_q)
          status_d = {2'b00, acc_step[WIDTH-1], (acc_step == '0)};
      end
    end else if (issue) begin
      if (is_mul) begin
        state_d = S_MUL;
      end else begin
        wb_valid_d = W;
        wb_addr_d  = DA;
        wb_data_d  = alu_res;
        if (FL)
          status_d = alu_flags;
      end
    end
  end

  // FSM, WB stage and Status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      status_q   <= '0;
    end else begin
      state_q    <= state_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      status_q   <= status_d;
    end
  end

  // Multiplier datapath: latch operands on issue, then one bit per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      mdest_q  <= '0;
      mw_q     <= 1'b0;
      mfl_q    <= 1'b0;
    end else if (state_q == S_MUL) begin
      acc_q    <= acc_step;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + SHW'(1);
    end else if (issue && is_mul) begin
      mcand_q  <= a_op;
      mplier_q <= b_op;
      acc_q    <= '0;
      cnt_q    <= '0;
      mdest_q  <= DA;
      mw_q     <= W;
      mfl_q    <= FL;
    end
  end

  // Regfile commit from the WB stage; the zero register is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= '0;
    end else if (wb_valid_q && (wb_addr_q != ZA)) begin
      regs_q[wb_addr_q] <= wb_data_q;
    end
  end

endmodule
